stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit streaming multiplexer with a registered output stage. It generalises the combinational 2:1 mux into a clocked selector for datapath plumbing between producers and a single consumer.
- Two selection modes: fixed (external select) and round-robin (fair scan of requesting channels).
- Optional bitwise inversion of the selected word, generalising the single-bit NOT-by-mux cell.
- Valid/ready handshake on every channel and on the output.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/rr_pick.sv | 37 +++
 rtl/stream_mux_rr.sv | 106 ++++++++++
 tb/tb_stream_mux_rr.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr block.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   next_idx()           : increment a channel index with wrap at n
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // (idx + 1) mod n, written without a divider
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : per-channel request vector
//   ptr   : channel with highest priority this cycle
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted channel (zero when no request)
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [SELW-1:0] idx
);

  logic [SELW-1:0] cand;
  logic            found;

  // Walk ptr, ptr+1, ... with wrap; the first requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = (32'(ptr) < N_CH) ? ptr : '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
      cand = SELW'(next_idx(32'(cand), N_CH));
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel streaming multiplexer with a single registered output stage.
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   mode               : 0 = fixed select via sel_fixed, 1 = round-robin
//   sel_fixed          : channel index used in fixed mode
//   invert             : invert the captured word bitwise
//   in_valid/in_ready  : per-channel handshake, in_ready is one-hot or zero
//   in_data            : channel k at bits [k*WIDTH +: WIDTH]
//   out_valid/out_ready: output handshake
//   out_data, out_ch   : registered word and the channel that supplied it
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SELW = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel_fixed,
  input  logic                  invert,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_ch,
  input  logic                  out_ready
);

  logic [N_CH-1:0]  fix_grant, rr_grant, grant;
  logic [SELW-1:0]  rr_idx, grant_idx;
  logic             can_accept, xfer;
  logic [WIDTH-1:0] sel_word;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  rr_pick #(
    .N_CH (N_CH),
    .SELW (SELW)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Out-of-range sel_fixed decodes to an all-zero grant.
  always_comb begin
    fix_grant = '0;
    for (int k = 0; k < N_CH; k++) begin
      fix_grant[k] = (sel_fixed == SELW'(k));
    end
  end

  assign grant      = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign grant_idx  = (mode == MODE_RR) ? rr_idx : sel_fixed;
  assign can_accept = !out_valid_q || out_ready;
  // Gate on rst: the register is empty during reset, so can_accept alone would be 1.
  assign in_ready   = rst ? '0 : (grant & {N_CH{can_accept}});
  assign xfer       = |(in_valid & in_ready);

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant[k]) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_word ^ {WIDTH{invert}};
      out_ch_d    = grant_idx;
      if (mode == MODE_RR) rr_ptr_d = SELW'(next_idx(32'(grant_idx), N_CH));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed vector table, hand-written
// backpressure/reset sequences, then random stimulus against a reference model.
module tb_stream_mux_rr;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SELW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mode;
  logic [SELW-1:0]       sel_fixed;
  logic                  invert;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_ready;

  always #5 clk = ~clk;

  stream_mux_rr #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel_fixed (sel_fixed),
    .invert    (invert),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents of the output register and the scan start.
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_ptr;

  typedef struct {
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic                  inv;
    logic [N_CH-1:0]       valid;
    logic [N_CH*WIDTH-1:0] data;
    logic                  ordy;
    logic [N_CH-1:0]       e_rdy;
    logic                  e_valid;
    logic [WIDTH-1:0]      e_data;
    logic [SELW-1:0]       e_ch;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Channel the rules grant this cycle, or -1.
  function automatic int model_grant();
    if (mode == 1'b0) return (int'(sel_fixed) < N_CH) ? int'(sel_fixed) : -1;
    for (int j = 0; j < N_CH; j++) begin
      if (in_valid[(m_ptr + j) % N_CH]) return (m_ptr + j) % N_CH;
    end
    return -1;
  endfunction

  // One clock with the current inputs. rdy is in_ready sampled before the edge.
  task automatic cycle(input bit use_model, output logic [N_CH-1:0] rdy);
    int              g;
    logic [N_CH-1:0] exp_rdy;
    #1;
    rdy     = in_ready;
    g       = model_grant();
    exp_rdy = '0;
    if (g >= 0 && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    if (use_model) check("rand in_ready", 32'(rdy), 32'(exp_rdy));
    if (exp_rdy != '0 && in_valid[g]) begin
      m_valid = 1'b1;
      m_data  = in_data[g*WIDTH +: WIDTH] ^ {WIDTH{invert}};
      m_ch    = g;
      if (mode) m_ptr = (g + 1) % N_CH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (use_model) begin
      check("rand out_valid", 32'(out_valid), 32'(m_valid));
      check("rand out_data", 32'(out_data), 32'(m_data));
      check("rand out_ch", 32'(out_ch), 32'(m_ch));
    end
  endtask

  function automatic vec_t mk(input logic md, input logic [SELW-1:0] sl, input logic iv,
                              input logic [N_CH-1:0] vl, input logic [31:0] dt,
                              input logic ordy, input logic [N_CH-1:0] er, input logic ev,
                              input logic [WIDTH-1:0] ed, input logic [SELW-1:0] ec);
    vec_t v;
    v.mode = md; v.sel = sl; v.inv = iv; v.valid = vl; v.data = dt; v.ordy = ordy;
    v.e_rdy = er; v.e_valid = ev; v.e_data = ed; v.e_ch = ec;
    return v;
  endfunction

  logic [N_CH-1:0] rdy;

  initial begin
    rst = 1'b1; mode = 1'b0; sel_fixed = '0; invert = 1'b0;
    in_valid = '0; in_data = '0; out_ready = 1'b0;
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_ch", 32'(out_ch), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // Fixed select, invert, then round-robin fairness and skip (ptr ends at 2).
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 4'hF, 32'h443322A5, 1'b1, 4'b0001, 1'b1, 8'h5A, 2'd0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 4'hF, 32'h443322A5, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 4'h0, 32'h443322A5, 1'b1, 4'b0001, 1'b0, 8'hA5, 2'd0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hF, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hA, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hA, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hA, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 4'hA, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1));

    foreach (vecs[i]) begin
      mode = vecs[i].mode; sel_fixed = vecs[i].sel; invert = vecs[i].inv;
      in_valid = vecs[i].valid; in_data = vecs[i].data; out_ready = vecs[i].ordy;
      cycle(1'b0, rdy);
      check($sformatf("vec%0d in_ready", i), 32'(rdy), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d out_ch", i), 32'(out_ch), 32'(vecs[i].e_ch));
    end

    // Backpressure: beat 0x22/ch1 held for 3 cycles, pointer frozen at 2.
    mode = 1'b1; invert = 1'b0; in_valid = 4'hF; in_data = 32'h44332211; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, rdy);
      check("bp in_ready", 32'(rdy), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_data", 32'(out_data), 32'h22);
      check("bp out_ch", 32'(out_ch), 32'd1);
    end
    out_ready = 1'b1;
    cycle(1'b0, rdy);
    check("bp release in_ready", 32'(rdy), 32'b0100);
    check("bp release out_valid", 32'(out_valid), 32'd1);
    check("bp release out_data", 32'(out_data), 32'h33);
    check("bp release out_ch", 32'(out_ch), 32'd2);

    // Reset mid-beat: effects are immediate, and scanning restarts at channel 0.
    rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data", 32'(out_data), 32'd0);
    check("midrst out_ch", 32'(out_ch), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd0);
    m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, rdy);
    check("postrst in_ready", 32'(rdy), 32'b0001);
    check("postrst out_data", 32'(out_data), 32'h11);
    check("postrst out_ch", 32'(out_ch), 32'd0);

    // Random traffic against the model.
    for (int t = 0; t < 600; t++) begin
      mode      = 1'($urandom_range(0, 1));
      sel_fixed = SELW'($urandom_range(0, N_CH - 1));
      invert    = 1'($urandom_range(0, 1));
      in_valid  = N_CH'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(1'b1, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
